// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the instruction-memory UART loader.
// Holds the loader state encoding, default frame marker, memory depth
// and timeout, and a helper that identifies the in-frame states.
package imem_uart_loader_pkg;

   localparam int unsigned IMEM_DEPTH             = 32;
   localparam logic [7:0]  SYNC_BYTE_DEFAULT      = 8'hA5;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_HI,
      ST_LO,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   // True while a frame is being received; drives busy and the idle timer.
   function automatic logic is_busy_state(input loader_state_t s);
      return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Bus between the UART receiver, the loader and the instruction memory.
//   rx_valid/rx_byte : received byte strobe and data (into the loader)
//   wr_en/wr_addr/wr_data : instruction-memory write port (from the loader)
//   load_done/load_error/busy/words_loaded : loader status (from the loader)
// master = loader side, slave = UART/memory/CPU side.
interface imem_uart_loader_if #(
   parameter int unsigned ADDR_W = 5
);

   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              load_done;
   logic              load_error;
   logic              busy;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      input  rx_valid, rx_byte,
      output wr_en, wr_addr, wr_data,
      output load_done, load_error, busy, words_loaded
   );

   modport slave (
      output rx_valid, rx_byte,
      input  wr_en, wr_addr, wr_data,
      input  load_done, load_error, busy, words_loaded
   );

endinterface

// File: rtl/imem_uart_loader_timeout_counter.sv
// Idle-cycle timer for byte-stream loaders.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart counting (a byte arrived)
//   enable   : count only while enabled; held at 0 otherwise
//   expired  : TIMEOUT_CYCLES-1 idle cycles have elapsed while enabled
module loader_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign expired = enable && (cnt == LAST);

   // Saturates at LAST so expired stays asserted until the owner reacts.
   always_ff @(posedge clk) begin
      if (rst || clear || !enable) begin
         cnt <= '0;
      end else if (!expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// Instruction-memory download sequencer.
// Parses frames of the form SYNC, LEN(1..2^ADDR_W), LEN x {hi, lo}, CSUM
// (CSUM = XOR of LEN and all data bytes) from the UART receiver and writes
// each assembled big-endian word to consecutive instruction addresses.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : rx byte input, memory write port and load status outputs
module imem_uart_loader
   import imem_uart_loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = $clog2(IMEM_DEPTH),
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
   input logic                CLK,
   input logic                RST,
   imem_uart_loader_if.master bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   loader_state_t state, state_n;

   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   word_idx;
   logic [ADDR_W:0]   word_idx_inc;
   logic [7:0]        hi;
   logic [7:0]        csum;
   logic              in_frame;
   logic              expired;
   logic              len_ok;
   logic              last_word;
   logic              csum_ok;

   logic              wr_en_q, wr_en_n;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic              done_q, done_n;
   logic              error_q, error_n;
   logic              busy_q, busy_n;
   logic [ADDR_W:0]   words_q;

   assign rx_valid     = bus.rx_valid;
   assign rx_byte      = bus.rx_byte;
   assign in_frame     = is_busy_state(state);
   assign word_idx_inc = word_idx + (ADDR_W+1)'(1);
   assign len_ok       = (rx_byte != 8'd0) && (32'(rx_byte) <= DEPTH);
   assign last_word    = (word_idx_inc >= len);
   assign csum_ok      = (rx_byte == csum);

   loader_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (CLK),
      .rst     (RST),
      .clear   (rx_valid),
      .enable  (in_frame),
      .expired (expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Status outputs are registered from the next state so they change one
   // cycle after the deciding byte, in step with the state register.
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (rx_valid && (rx_byte == SYNC_BYTE)) state_n = ST_LEN;
         end
         ST_LEN: begin
            if (rx_valid) state_n = len_ok ? ST_HI : ST_ERROR;
         end
         ST_HI: begin
            if (rx_valid) state_n = ST_LO;
         end
         ST_LO: begin
            if (rx_valid) state_n = last_word ? ST_CSUM : ST_HI;
         end
         ST_CSUM: begin
            if (rx_valid) state_n = csum_ok ? ST_DONE : ST_ERROR;
         end
         default: state_n = ST_IDLE;
      endcase
      // A byte arriving on the expiry cycle takes precedence over the timeout.
      if (in_frame && expired && !rx_valid) state_n = ST_ERROR;

      wr_en_n = (state == ST_LO) && rx_valid;
      done_n  = (state_n == ST_DONE);
      error_n = (state_n == ST_ERROR);
      busy_n  = is_busy_state(state_n);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
         words_q   <= '0;
         len       <= '0;
         word_idx  <= '0;
         hi        <= '0;
         csum      <= '0;
      end else begin
         wr_en_q <= wr_en_n;
         done_q  <= done_n;
         error_q <= error_n;
         busy_q  <= busy_n;
         if (rx_valid) begin
            unique case (state)
               ST_LEN: begin
                  len      <= rx_byte[ADDR_W:0];
                  word_idx <= '0;
                  csum     <= rx_byte;
               end
               ST_HI: begin
                  hi   <= rx_byte;
                  csum <= csum ^ rx_byte;
               end
               ST_LO: begin
                  csum      <= csum ^ rx_byte;
                  wr_addr_q <= word_idx[ADDR_W-1:0];
                  wr_data_q <= {hi, rx_byte};
                  word_idx  <= word_idx_inc;
               end
               ST_CSUM: begin
                  if (csum_ok) words_q <= len;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.load_done    = done_q;
   assign bus.load_error   = error_q;
   assign bus.busy         = busy_q;
   assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: directed frames with literal
// expectations plus randomized frames checked every cycle against a
// frame-level behavioural model.
module tb_imem_uart_loader;

   localparam int unsigned AW = 5;
   localparam int unsigned TO = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_uart_loader_if #(.ADDR_W(AW)) bus ();

   imem_uart_loader #(
      .ADDR_W         (AW),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_on  = 1'b0;
   logic [AW+15:0] wr_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: position within the frame decides the byte's role.
   bit        m_active = 0;
   int        m_pos    = 0;
   int        m_len    = 0;
   int        m_idle   = 0;
   logic [7:0] m_x     = '0;
   logic [7:0] m_hi    = '0;
   bit        m_done   = 0;
   bit        m_err    = 0;
   int        m_words  = 0;
   bit        m_wr_en  = 0;
   int        m_wr_addr = 0;
   logic [15:0] m_wr_data = '0;

   always @(posedge clk) begin
      int b;
      m_wr_en = 0;
      if (rst) begin
         m_active = 0; m_done = 0; m_err = 0; m_words = 0; m_idle = 0;
      end else if (bus.rx_valid) begin
         b = int'(bus.rx_byte);
         if (!m_active) begin
            if (b == 'hA5) begin
               m_active = 1; m_pos = 0; m_done = 0; m_err = 0; m_idle = 0;
            end
         end else begin
            m_idle = 0;
            if (m_pos == 0) begin
               if (b == 0 || b > 32) begin
                  m_active = 0; m_err = 1;
               end else begin
                  m_len = b; m_x = 8'(b);
               end
            end else if (m_pos <= 2 * m_len) begin
               m_x = m_x ^ 8'(b);
               if (m_pos % 2 == 1) m_hi = 8'(b);
               else begin
                  m_wr_en = 1; m_wr_addr = m_pos / 2 - 1; m_wr_data = {m_hi, 8'(b)};
               end
            end else begin
               m_active = 0;
               if (8'(b) == m_x) begin m_done = 1; m_words = m_len; end
               else m_err = 1;
            end
            m_pos++;
         end
      end else if (m_active) begin
         m_idle++;
         if (m_idle == TO) begin m_active = 0; m_err = 1; end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("wr_en", bus.wr_en, m_wr_en);
         if (m_wr_en) begin
            check("wr_addr", bus.wr_addr, m_wr_addr);
            check("wr_data", bus.wr_data, m_wr_data);
         end
         check("load_done", bus.load_done, m_done);
         check("load_error", bus.load_error, m_err);
         check("busy", bus.busy, m_active);
         check("words_loaded", bus.words_loaded, m_words);
         if (bus.wr_en) wr_log.push_back({bus.wr_addr, bus.wr_data});
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'($urandom);
   endtask

   task automatic send_good_short();
      send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
      send(8'h42);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_wr_en"}, bus.wr_en, 0);
      check({tag, "_wr_addr"}, bus.wr_addr, 0);
      check({tag, "_wr_data"}, bus.wr_data, 0);
      check({tag, "_done"}, bus.load_done, 0);
      check({tag, "_error"}, bus.load_error, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_words"}, bus.words_loaded, 0);
   endtask

   initial begin
      logic [7:0] fb[$];
      logic [7:0] x;
      int len, mode, cut, g;
      logic [15:0] w;

      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      @(posedge clk); #1;
      cmp_on = 1'b1;
      idle(2);
      check_quiet("reset");
      rst = 1'b0;
      idle(2);

      // Two-word frame, correct checksum.
      wr_log.delete();
      send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
      check("t1_done_before_cs", bus.load_done, 0);
      check("t1_busy_before_cs", bus.busy, 1);
      send(8'h42);
      check("t1_done", bus.load_done, 1);
      check("t1_error", bus.load_error, 0);
      check("t1_words", bus.words_loaded, 2);
      check("t1_nwr", wr_log.size(), 2);
      check("t1_w0", wr_log[0], {5'd0, 16'h1234});
      check("t1_w1", wr_log[1], {5'd1, 16'hABCD});

      // Bad checksum: words still written, error raised, then recovery.
      wr_log.delete();
      send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
      send(8'h43);
      check("t2_error", bus.load_error, 1);
      check("t2_done", bus.load_done, 0);
      check("t2_nwr", wr_log.size(), 2);
      send(8'hA5);
      check("t2_error_clear", bus.load_error, 0);
      send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h42);
      check("t2_done_after", bus.load_done, 1);

      // Illegal lengths.
      wr_log.delete();
      send(8'hA5); send(8'h00);
      check("t3_len0_error", bus.load_error, 1);
      check("t3_len0_busy", bus.busy, 0);
      send(8'hA5); send(8'h21);
      check("t3_len33_error", bus.load_error, 1);
      check("t3_len33_busy", bus.busy, 0);
      idle(3);
      check("t3_nwr", wr_log.size(), 0);

      // Timeout after the hi byte, and a byte landing exactly on expiry.
      wr_log.delete();
      send(8'hA5); send(8'h01); send(8'h12);
      idle(TO - 1);
      check("t4_error_early", bus.load_error, 0);
      check("t4_busy_early", bus.busy, 1);
      idle(1);
      check("t4_error", bus.load_error, 1);
      check("t4_busy", bus.busy, 0);
      check("t4_nwr", wr_log.size(), 0);
      send(8'hA5); send(8'h01); send(8'h12);
      idle(TO - 1);
      send(8'h34); send(8'h27);
      check("t4b_done", bus.load_done, 1);
      check("t4b_error", bus.load_error, 0);

      // Full-depth frame, then a reload drops load_done while in progress.
      wr_log.delete();
      send(8'hA5); send(8'h20);
      for (int i = 0; i < 32; i++) begin
         send(8'h00); send(8'(i));
      end
      send(8'h20);
      check("t5_done", bus.load_done, 1);
      check("t5_words", bus.words_loaded, 32);
      check("t5_nwr", wr_log.size(), 32);
      for (int i = 0; i < 32; i++) check("t5_wr", wr_log[i], {5'(i), 16'(i)});
      send(8'hA5);
      check("t5_reload_done", bus.load_done, 0);
      check("t5_reload_busy", bus.busy, 1);
      send(8'h01); send(8'h00); send(8'h07); send(8'h06);
      check("t5_reload_ok", bus.load_done, 1);

      // Reset during the low byte of word 3.
      wr_log.delete();
      send(8'hA5); send(8'h04);
      for (int i = 0; i < 3; i++) begin send(8'h10); send(8'(i)); end
      send(8'h10);
      rst = 1'b1;
      send(8'h03);
      rst = 1'b0;
      check_quiet("t6");
      check("t6_nwr", wr_log.size(), 3);
      send(8'h12);
      check("t6_ignored_busy", bus.busy, 0);
      check("t6_ignored_error", bus.load_error, 0);

      // Randomized frames checked by the model every cycle.
      send_good_short();
      for (int f = 0; f < 40; f++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            x = 8'($urandom);
            if (x == 8'hA5) x = 8'h5A;
            send(x);
            idle($urandom_range(0, 2));
         end
         mode = $urandom_range(0, 7);
         len  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 32);
         fb.delete();
         fb.push_back(8'hA5);
         if (mode == 2) begin
            fb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
         end else begin
            fb.push_back(8'(len));
            x = 8'(len);
            for (int i = 0; i < len; i++) begin
               w = 16'($urandom);
               fb.push_back(w[15:8]);
               fb.push_back(w[7:0]);
               x = x ^ w[15:8] ^ w[7:0];
            end
            fb.push_back((mode == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
         end
         cut = (mode == 1) ? $urandom_range(1, fb.size() - 1) : fb.size();
         for (int i = 0; i < cut; i++) begin
            send(fb[i]);
            g = ($urandom_range(0, 15) == 0) ? int'(TO) - 1 : $urandom_range(0, 2);
            idle(g);
         end
         if (mode == 1) idle(TO + 5);
         else idle(2);
      end

      idle(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
